mini_src_control_unit: RTL and testbench

- Hardwired Moore control sequencer for the Mini SRC DataPath.
- Replaces the hand-stepped T0..Tn testbench sequencing: it generates every register-enable, bus-drive, memory and ALU control for fetch and execute.
- Reads the opcode from the IR, the CON FF result and a memory-ready handshake.
- Sits beside DataPath in the CPU top level and drives its control ports one-to-one.

---
 rtl/mini_src_pkg.sv | 44 ++++
 rtl/mini_src_control_unit.sv | 145 ++++++++++++++
 tb/tb_mini_src_control_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mini_src_pkg.sv
// Shared opcode, ALU and state definitions for the Mini SRC control unit.
package mini_src_pkg;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_BR   = 5'b10011;
  localparam logic [OPW-1:0] OP_JR   = 5'b10100;
  localparam logic [OPW-1:0] OP_JAL  = 5'b10101;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  localparam logic [OPW-1:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  // Instruction families that share an execute sequence.
  typedef enum logic [3:0] {
    C_ALU, C_ADDI, C_LD, C_ST, C_BR, C_JR, C_JAL, C_HALT, C_NOP
  } op_class_e;

  function automatic op_class_e op_class(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = C_ALU;
      OP_ADDI: op_class = C_ADDI;
      OP_LD:   op_class = C_LD;
      OP_ST:   op_class = C_ST;
      OP_BR:   op_class = C_BR;
      OP_JR:   op_class = C_JR;
      OP_JAL:  op_class = C_JAL;
      OP_HALT: op_class = C_HALT;
      default: op_class = C_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mini_src_control_unit.sv
// Hardwired Moore sequencer driving the Mini SRC datapath controls.
module mini_src_control_unit
  import mini_src_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_rdy,
  output logic        Pout,
  output logic        MARen,
  output logic        MDRen,
  output logic        MDROut,
  output logic        IRen,
  output logic        Pen,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        ConIn,
  output logic        Yen,
  output logic        ZLOen,
  output logic        ZHIen,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        R15en,
  output logic [4:0]  alu_control,
  output logic        run
);

  state_e          state_q, state_d;
  logic [OPW-1:0]  opcode;
  op_class_e       cls;
  logic            unused_ir;

  assign opcode    = ir[31:32-OPW];
  assign cls       = op_class(opcode);
  assign unused_ir = ^ir[31-OPW:0];

  // State register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) state_q <= S_RST;
    else     state_q <= state_d;
  end

  // Next-state: fetch, then dispatch on the opcode class from T3.
  always_comb begin
    state_d = S_T0;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = mem_rdy ? S_T2 : S_T1;
      S_T2:   state_d = S_T3;
      S_T3: begin
        case (cls)
          C_ALU, C_ADDI, C_LD, C_ST, C_BR, C_JAL: state_d = S_T4;
          C_HALT:  state_d = S_HALT;
          default: state_d = S_T0;
        endcase
      end
      S_T4:   state_d = (cls == C_JAL) ? S_T0 : S_T5;
      S_T5:   state_d = (cls inside {C_LD, C_ST, C_BR}) ? S_T6 : S_T0;
      S_T6: begin
        case (cls)
          C_LD:    state_d = mem_rdy ? S_T7 : S_T6;
          C_ST:    state_d = S_T7;
          default: state_d = S_T0;
        endcase
      end
      S_T7: begin
        if (cls == C_ST) state_d = mem_rdy ? S_T0 : S_T7;
        else             state_d = S_T0;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Output decode from (state, opcode); br's T6 PC load is gated by con_ff.
  always_comb begin
    Pout = 1'b0; MARen = 1'b0; MDRen = 1'b0; MDROut = 1'b0; IRen = 1'b0;
    Pen = 1'b0; IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; Cout = 1'b0; ConIn = 1'b0;
    Yen = 1'b0; ZLOen = 1'b0; ZHIen = 1'b0; ZLOout = 1'b0; ZHIout = 1'b0;
    R15en = 1'b0;
    alu_control = '0;
    run = (state_q != S_HALT);
    case (state_q)
      S_T0: begin Pout = 1'b1; MARen = 1'b1; IncPC = 1'b1; ZLOen = 1'b1; end
      S_T1: begin ZLOout = 1'b1; Pen = 1'b1; Read = 1'b1; MDRen = 1'b1; end
      S_T2: begin MDROut = 1'b1; IRen = 1'b1; end
      S_T3: begin
        case (cls)
          C_ALU, C_ADDI: begin Grb = 1'b1; Rout = 1'b1; Yen = 1'b1; end
          C_LD, C_ST:    begin Grb = 1'b1; BAout = 1'b1; Yen = 1'b1; end
          C_BR:          begin Gra = 1'b1; Rout = 1'b1; ConIn = 1'b1; end
          C_JR:          begin Gra = 1'b1; Rout = 1'b1; Pen = 1'b1; end
          C_JAL:         begin Pout = 1'b1; R15en = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_ALU: begin Grc = 1'b1; Rout = 1'b1; alu_control = opcode; ZLOen = 1'b1; end
          C_ADDI, C_LD, C_ST: begin Cout = 1'b1; alu_control = ALU_ADD; ZLOen = 1'b1; end
          C_BR:  begin Pout = 1'b1; Yen = 1'b1; end
          C_JAL: begin Gra = 1'b1; Rout = 1'b1; Pen = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_ALU, C_ADDI: begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_LD, C_ST:    begin ZLOout = 1'b1; MARen = 1'b1; end
          C_BR:          begin Cout = 1'b1; alu_control = ALU_ADD; ZLOen = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          C_LD: begin Read = 1'b1; MDRen = 1'b1; end
          C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRen = 1'b1; end
          C_BR: begin ZLOout = 1'b1; Pen = con_ff; end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD: begin MDROut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Randomized scoreboard bench for mini_src_control_unit.
module tb_mini_src_control_unit;

  logic        clk = 1'b0;
  logic        clr, con_ff, mem_rdy;
  logic [31:0] ir;
  logic Pout, MARen, MDRen, MDROut, IRen, Pen, IncPC, Read, Write;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, ConIn;
  logic Yen, ZLOen, ZHIen, ZLOout, ZHIout, R15en, run;
  logic [4:0]  alu_control;
  logic [28:0] dut_word;

  always #5 clk = ~clk;

  mini_src_control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .mem_rdy(mem_rdy),
    .Pout(Pout), .MARen(MARen), .MDRen(MDRen), .MDROut(MDROut), .IRen(IRen),
    .Pen(Pen), .IncPC(IncPC), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .Cout(Cout), .ConIn(ConIn),
    .Yen(Yen), .ZLOen(ZLOen), .ZHIen(ZHIen), .ZLOout(ZLOout), .ZHIout(ZHIout),
    .R15en(R15en), .alu_control(alu_control), .run(run)
  );

  assign dut_word = {alu_control, run, R15en, ZHIout, ZLOout, ZHIen, ZLOen, Yen,
                     ConIn, Cout, BAout, Rout, Rin, Grc, Grb, Gra,
                     Write, Read, IncPC, Pen, IRen, MDROut, MDRen, MARen, Pout};

  // Control-word bit masks (same packing as dut_word).
  localparam logic [28:0] M_POUT = 29'h1 << 0,  M_MAREN = 29'h1 << 1,  M_MDREN = 29'h1 << 2;
  localparam logic [28:0] M_MDROUT = 29'h1 << 3, M_IREN = 29'h1 << 4,  M_PEN = 29'h1 << 5;
  localparam logic [28:0] M_INCPC = 29'h1 << 6, M_READ = 29'h1 << 7,  M_WRITE = 29'h1 << 8;
  localparam logic [28:0] M_GRA = 29'h1 << 9,   M_GRB = 29'h1 << 10,  M_GRC = 29'h1 << 11;
  localparam logic [28:0] M_RIN = 29'h1 << 12,  M_ROUT = 29'h1 << 13, M_BAOUT = 29'h1 << 14;
  localparam logic [28:0] M_COUT = 29'h1 << 15, M_CONIN = 29'h1 << 16, M_YEN = 29'h1 << 17;
  localparam logic [28:0] M_ZLOEN = 29'h1 << 18, M_ZLOOUT = 29'h1 << 20;
  localparam logic [28:0] M_R15EN = 29'h1 << 22, M_RUN = 29'h1 << 23;

  localparam logic [4:0] A_LD = 5'b00000, A_ST = 5'b00010, A_ADD = 5'b00011;
  localparam logic [4:0] A_SUB = 5'b00100, A_AND = 5'b00101, A_OR = 5'b00110;
  localparam logic [4:0] A_ADDI = 5'b01100, A_BR = 5'b10011, A_JR = 5'b10100;
  localparam logic [4:0] A_JAL = 5'b10101, A_NOP = 5'b11010, A_HALT = 5'b11011;

  function automatic logic [28:0] alu(input logic [4:0] c);
    return {c, 24'h0};
  endfunction

  typedef struct { logic [28:0] w; string tag; } exp_t;
  typedef struct { logic [28:0] w; bit mw; string tag; } step_t;

  exp_t  sb[$];
  step_t prog[$];
  int    checks = 0;
  int    errors = 0;

  task automatic add_step(input logic [28:0] w, input bit mw, input string tag);
    step_t s;
    s.w = w | M_RUN; s.mw = mw; s.tag = tag;
    prog.push_back(s);
  endtask

  // Reference: the per-step control list of one instruction, straight from the step tables.
  task automatic build(input logic [4:0] op, input logic con);
    prog.delete();
    add_step(M_POUT | M_MAREN | M_INCPC | M_ZLOEN, 0, "T0");
    add_step(M_ZLOOUT | M_PEN | M_READ | M_MDREN, 1, "T1");
    add_step(M_MDROUT | M_IREN, 0, "T2");
    if (op inside {A_ADD, A_SUB, A_AND, A_OR}) begin
      add_step(M_GRB | M_ROUT | M_YEN, 0, "alu_T3");
      add_step(M_GRC | M_ROUT | M_ZLOEN | alu(op), 0, "alu_T4");
      add_step(M_ZLOOUT | M_GRA | M_RIN, 0, "alu_T5");
    end else if (op == A_ADDI) begin
      add_step(M_GRB | M_ROUT | M_YEN, 0, "addi_T3");
      add_step(M_COUT | M_ZLOEN | alu(5'b00011), 0, "addi_T4");
      add_step(M_ZLOOUT | M_GRA | M_RIN, 0, "addi_T5");
    end else if (op == A_LD || op == A_ST) begin
      add_step(M_GRB | M_BAOUT | M_YEN, 0, "mem_T3");
      add_step(M_COUT | M_ZLOEN | alu(5'b00011), 0, "mem_T4");
      add_step(M_ZLOOUT | M_MAREN, 0, "mem_T5");
      if (op == A_LD) begin
        add_step(M_READ | M_MDREN, 1, "ld_T6");
        add_step(M_MDROUT | M_GRA | M_RIN, 0, "ld_T7");
      end else begin
        add_step(M_GRA | M_ROUT | M_MDREN, 0, "st_T6");
        add_step(M_WRITE, 1, "st_T7");
      end
    end else if (op == A_BR) begin
      add_step(M_GRA | M_ROUT | M_CONIN, 0, "br_T3");
      add_step(M_POUT | M_YEN, 0, "br_T4");
      add_step(M_COUT | M_ZLOEN | alu(5'b00011), 0, "br_T5");
      add_step(M_ZLOOUT | (con ? M_PEN : 29'h0), 0, "br_T6");
    end else if (op == A_JR) begin
      add_step(M_GRA | M_ROUT | M_PEN, 0, "jr_T3");
    end else if (op == A_JAL) begin
      add_step(M_POUT | M_R15EN, 0, "jal_T3");
      add_step(M_GRA | M_ROUT | M_PEN, 0, "jal_T4");
    end else begin
      add_step('0, 0, "idle_T3");
    end
  endtask

  task automatic tick(input logic [28:0] w, input string tag);
    exp_t e;
    e.w = w; e.tag = tag;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  // xw<0: random waits everywhere; else no fetch wait and xw execute waits.
  task automatic run_instr(input logic [4:0] op, input logic con, input int xw, input int abort_at);
    build(op, con);
    ir = {op, 27'($urandom)};
    con_ff = con;
    foreach (prog[i]) begin
      int n;
      n = 0;
      if (prog[i].mw) n = (xw < 0) ? int'($urandom_range(0, 2)) : ((i == 1) ? 0 : xw);
      for (int k = 0; k <= n; k++) begin
        if (prog[i].mw) mem_rdy = (k == n);
        else            mem_rdy = 1'($urandom_range(0, 1));
        if (i == abort_at) begin
          clr = 1'b1;
          tick(prog[i].w, prog[i].tag);
          tick(M_RUN, "rst_hold");
          clr = 1'b0;
          tick(M_RUN, "rst_release");
          return;
        end
        tick(prog[i].w, prog[i].tag);
      end
    end
  endtask

  // Monitor: one expected control word per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (dut_word !== e.w) begin
        errors++;
        $display("FAIL %s: got %h expected %h (t=%0t)", e.tag, dut_word, e.w, $time);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] op;
    clr = 1'b1; ir = '0; con_ff = 1'b0; mem_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    tick(M_RUN, "reset_state");

    run_instr(A_ADD, 1'b0, 0, 5);
    run_instr(A_ADD, 1'b0, 0, -1);
    run_instr(A_LD, 1'b0, 3, -1);
    run_instr(A_ST, 1'b1, 2, -1);
    run_instr(A_BR, 1'b0, 0, -1);
    run_instr(A_BR, 1'b1, 0, -1);
    run_instr(A_JAL, 1'b0, 0, -1);
    run_instr(A_JR, 1'b1, 0, -1);
    run_instr(A_ADDI, 1'b0, 0, -1);
    run_instr(A_NOP, 1'b0, 0, -1);
    run_instr(A_OR, 1'b0, 0, -1);

    for (int n = 0; n < 200; n++) begin
      op = 5'($urandom);
      if (op == A_HALT) op = A_NOP;
      run_instr(op, 1'($urandom_range(0, 1)), -1, -1);
    end

    run_instr(A_HALT, 1'b0, 0, -1);
    repeat (10) begin
      mem_rdy = 1'($urandom_range(0, 1));
      con_ff  = 1'($urandom_range(0, 1));
      tick('0, "halted");
    end
    clr = 1'b1;
    tick('0, "halt_clr");
    clr = 1'b0;
    tick(M_RUN, "rst_after_halt");
    run_instr(A_SUB, 1'b0, 0, -1);

    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
